l1_pte_responder: RTL and testbench

L1_PTE_RESPONDER -- requirements
Module: l1_pte_responder

---
 rtl/l1_pte_responder.sv | 123 ++++++++++++
 tb/tb_l1_pte_responder.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/l1_pte_responder.sv
`default_nettype none
// ------------------------------------------------------------------------------
// l1_pte_responder: direct-mapped PTE cache for a page walker, single outstanding miss.
// Rev 1.0
// ------------------------------------------------------------------------------
module l1_pte_responder #(
  parameter int ENTRIES = 8
) (
  input  logic        clk_i,
  input  logic        resetn_i,
  input  logic [27:0] l1_va_i,
  input  logic        l1_va_vld_i,
  input  logic        l1_cancel_i,
  output logic [31:0] l1_pa_o,
  output logic        l1_vld_o,
  output logic        busy_o,
  output logic [25:0] mem_addr_o,
  output logic        mem_req_o,
  input  logic        mem_gnt_i,
  input  logic [31:0] mem_data_i,
  input  logic        mem_vld_i,
  input  logic        inv_i
);
  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = 26 - IDX_W;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOOKUP    = 3'd1,
    MISS_REQ  = 3'd2,
    MISS_WAIT = 3'd3,
    RESP      = 3'd4
  } state_t;

  state_t             state;
  logic [25:0]        req_word;
  logic [ENTRIES-1:0] valid;
  logic [TAG_W-1:0]   tag_mem  [ENTRIES];
  logic [31:0]        data_mem [ENTRIES];

  logic [IDX_W-1:0]   req_idx;
  logic [TAG_W-1:0]   req_tag;
  logic               hit;
  logic               fill;
  logic               unused_bits;

  assign req_idx     = req_word[IDX_W-1:0];
  assign req_tag     = req_word[25:IDX_W];
  assign hit         = valid[req_idx] && (tag_mem[req_idx] == req_tag);
  assign fill        = (state == MISS_WAIT) && mem_vld_i;
  assign busy_o      = (state != IDLE);
  assign unused_bits = &{1'b0, l1_va_i[1:0]};

  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      state      <= IDLE;
      req_word   <= '0;
      l1_vld_o   <= 1'b0;
      l1_pa_o    <= '0;
      mem_req_o  <= 1'b0;
      mem_addr_o <= '0;
    end else begin
      l1_vld_o <= 1'b0;
      case (state)
        IDLE: begin
          if (l1_va_vld_i) begin
            req_word <= l1_va_i[27:2];
            state    <= LOOKUP;
          end
        end
        LOOKUP: begin
          if (l1_cancel_i) begin
            state <= IDLE;
          end else if (hit) begin
            state    <= RESP;
            l1_vld_o <= 1'b1;
            l1_pa_o  <= data_mem[req_idx];
          end else begin
            state      <= MISS_REQ;
            mem_req_o  <= 1'b1;
            mem_addr_o <= req_word;
          end
        end
        MISS_REQ: begin
          if (mem_gnt_i) begin
            state      <= MISS_WAIT;
            mem_req_o  <= 1'b0;
            mem_addr_o <= '0;
          end
        end
        MISS_WAIT: begin
          if (mem_vld_i) begin
            state    <= RESP;
            l1_vld_o <= 1'b1;
            l1_pa_o  <= mem_data_i;
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Invalidate has priority over a coincident fill so the entry stays invalid.
  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      valid <= '0;
    end else if (inv_i) begin
      valid <= '0;
    end else if (fill) begin
      valid[req_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (fill) begin
      tag_mem[req_idx]  <= req_tag;
      data_mem[req_idx] <= mem_data_i;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_l1_pte_responder.sv
`timescale 1ns/1ps
`default_nettype none
// tb_l1_pte_responder: randomized transactions checked every cycle against a
// transaction-level cache model, plus directed scenarios with literal expectations.
module tb_l1_pte_responder;
  localparam int ENTRIES = 8;

  logic        clk_i = 1'b0;
  logic        resetn_i = 1'b0;
  logic [27:0] l1_va_i = '0;
  logic        l1_va_vld_i = 1'b0;
  logic        l1_cancel_i = 1'b0;
  logic [31:0] l1_pa_o;
  logic        l1_vld_o;
  logic        busy_o;
  logic [25:0] mem_addr_o;
  logic        mem_req_o;
  logic        mem_gnt_i = 1'b0;
  logic [31:0] mem_data_i = '0;
  logic        mem_vld_i = 1'b0;
  logic        inv_i = 1'b0;

  l1_pte_responder #(.ENTRIES(ENTRIES)) dut (
    .clk_i(clk_i), .resetn_i(resetn_i),
    .l1_va_i(l1_va_i), .l1_va_vld_i(l1_va_vld_i), .l1_cancel_i(l1_cancel_i),
    .l1_pa_o(l1_pa_o), .l1_vld_o(l1_vld_o), .busy_o(busy_o),
    .mem_addr_o(mem_addr_o), .mem_req_o(mem_req_o), .mem_gnt_i(mem_gnt_i),
    .mem_data_i(mem_data_i), .mem_vld_i(mem_vld_i), .inv_i(inv_i)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_fail = 0;

  // Cache model: per-index valid/tag/data, updated at transaction level.
  bit          m_valid [ENTRIES];
  int          m_tag   [ENTRIES];
  logic [31:0] m_data  [ENTRIES];

  bit          chk_en = 1'b0;
  logic        exp_busy = 1'b0, exp_vld = 1'b0, exp_req = 1'b0;
  logic [25:0] exp_addr = '0;
  logic [31:0] exp_pa = '0;
  int          inv_pct = 0;

  int          vld_count = 0, req_count = 0;
  logic [31:0] seen_pa = '0;
  logic [25:0] seen_addr = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk_i) begin
    if (chk_en) begin
      chk("busy_o", 32'(busy_o), 32'(exp_busy));
      chk("l1_vld_o", 32'(l1_vld_o), 32'(exp_vld));
      chk("l1_pa_o", l1_pa_o, exp_pa);
      chk("mem_req_o", 32'(mem_req_o), 32'(exp_req));
      chk("mem_addr_o", 32'(mem_addr_o), 32'(exp_addr));
    end
    if (l1_vld_o) begin vld_count++; seen_pa = l1_pa_o; end
    if (mem_req_o) begin req_count++; seen_addr = mem_addr_o; end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic bit rinv();
    return $urandom_range(0, 99) < 32'(inv_pct);
  endfunction

  task automatic model_clear();
    foreach (m_valid[i]) m_valid[i] = 1'b0;
  endtask

  task automatic set_exp(input logic b, input logic v, input logic r, input logic [25:0] a);
    exp_busy = b; exp_vld = v; exp_req = r; exp_addr = a;
  endtask

  // Inputs the DUT must ignore in the current state get random values.
  task automatic noise();
    l1_va_vld_i = 1'($urandom);
    l1_va_i     = 28'($urandom);
    l1_cancel_i = 1'($urandom);
    mem_gnt_i   = 1'($urandom);
    mem_vld_i   = 1'($urandom);
    mem_data_i  = $urandom;
  endtask

  task automatic end_cycle(input bit inv);
    inv_i = inv;
    @(posedge clk_i); #1;
    if (inv) model_clear();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      set_exp(1'b0, 1'b0, 1'b0, '0);
      noise();
      l1_va_vld_i = 1'b0;
      end_cycle(rinv());
    end
  endtask

  task automatic do_req(input logic [27:0] va, input bit cancel, input int gdly,
                        input int wdly, input logic [31:0] d, input bit inv_fill);
    logic [25:0] w;
    int idx, tag;
    bit hit;
    logic [31:0] rdata;
    w   = va[27:2];
    idx = int'(w) % ENTRIES;
    tag = int'(w) / ENTRIES;
    set_exp(1'b0, 1'b0, 1'b0, '0);
    noise();
    l1_va_i = va; l1_va_vld_i = 1'b1;
    end_cycle(rinv());
    set_exp(1'b1, 1'b0, 1'b0, '0);
    noise();
    l1_cancel_i = cancel;
    hit = m_valid[idx] && (m_tag[idx] == tag);
    rdata = m_data[idx];
    end_cycle(rinv());
    if (cancel) return;
    if (!hit) begin
      for (int i = 0; i <= gdly; i++) begin
        set_exp(1'b1, 1'b0, 1'b1, w);
        noise();
        mem_gnt_i = (i == gdly);
        end_cycle(rinv());
      end
      for (int i = 0; i <= wdly; i++) begin
        set_exp(1'b1, 1'b0, 1'b0, '0);
        noise();
        if (i == wdly) begin
          mem_vld_i = 1'b1; mem_data_i = d;
          m_valid[idx] = 1'b1; m_tag[idx] = tag; m_data[idx] = d;
          end_cycle(inv_fill | rinv());
        end else begin
          mem_vld_i = 1'b0;
          end_cycle(rinv());
        end
      end
      rdata = d;
    end
    exp_pa = rdata;
    set_exp(1'b1, 1'b1, 1'b0, '0);
    noise();
    end_cycle(rinv());
  endtask

  initial begin
    int v0, r0;
    logic [25:0] w;
    model_clear();
    #12;
    chk("reset busy_o", 32'(busy_o), 32'd0);
    chk("reset l1_vld_o", 32'(l1_vld_o), 32'd0);
    chk("reset l1_pa_o", l1_pa_o, 32'd0);
    chk("reset mem_req_o", 32'(mem_req_o), 32'd0);
    chk("reset mem_addr_o", 32'(mem_addr_o), 32'd0);
    @(posedge clk_i); #1;
    resetn_i = 1'b1;
    chk_en = 1'b1;
    idle(2);

    // Cold miss then hit.
    v0 = vld_count; r0 = req_count;
    do_req(28'h0000104, 1'b0, 1, 3, 32'hABCD1000, 1'b0);
    chk("cold miss mem_addr", 32'(seen_addr), 32'h41);
    chk("cold miss data", seen_pa, 32'hABCD1000);
    chk("cold miss one pulse", 32'(vld_count - v0), 32'd1);
    chk("cold miss requested", 32'(req_count > r0), 32'd1);
    idle(1);
    v0 = vld_count; r0 = req_count;
    do_req(28'h0000104, 1'b0, 0, 0, 32'h0, 1'b0);
    chk("hit data", seen_pa, 32'hABCD1000);
    chk("hit no mem_req", 32'(req_count - r0), 32'd0);
    chk("hit one pulse", 32'(vld_count - v0), 32'd1);

    // Cancel, then a request in the very next cycle.
    v0 = vld_count; r0 = req_count;
    do_req(28'h0000208, 1'b1, 0, 0, 32'h0, 1'b0);
    chk("cancel no response", 32'(vld_count - v0), 32'd0);
    chk("cancel no mem_req", 32'(req_count - r0), 32'd0);
    do_req(28'h0000208, 1'b0, 0, 1, 32'h22220208, 1'b0);
    chk("after cancel accepted", 32'(vld_count - v0), 32'd1);
    chk("after cancel data", seen_pa, 32'h22220208);

    // Conflict on index 1.
    r0 = req_count;
    do_req(28'h0000124, 1'b0, 2, 1, 32'h12400000, 1'b0);
    chk("conflict second misses", 32'(req_count > r0), 32'd1);
    r0 = req_count;
    do_req(28'h0000104, 1'b0, 0, 2, 32'hABCD1001, 1'b0);
    chk("conflict reread misses", 32'(req_count > r0), 32'd1);
    chk("conflict reread data", seen_pa, 32'hABCD1001);

    // Invalidate coincident with the fill.
    v0 = vld_count;
    do_req(28'h0000300, 1'b0, 0, 2, 32'h5EED0300, 1'b1);
    chk("inv fill response", 32'(vld_count - v0), 32'd1);
    chk("inv fill data", seen_pa, 32'h5EED0300);
    r0 = req_count;
    do_req(28'h0000300, 1'b0, 1, 0, 32'h5EED0301, 1'b0);
    chk("inv next access misses", 32'(req_count > r0), 32'd1);

    // Reset while waiting for fill data.
    w = 26'h100;
    do_req(28'h0000400, 1'b0, 0, 0, 32'h44440400, 1'b0);
    set_exp(1'b0, 1'b0, 1'b0, '0); noise(); l1_va_vld_i = 1'b1; l1_va_i = 28'h0000404;
    end_cycle(1'b0);
    set_exp(1'b1, 1'b0, 1'b0, '0); noise(); l1_cancel_i = 1'b0; end_cycle(1'b0);
    set_exp(1'b1, 1'b0, 1'b1, w + 26'd1); noise(); mem_gnt_i = 1'b1; end_cycle(1'b0);
    set_exp(1'b1, 1'b0, 1'b0, '0); noise(); mem_vld_i = 1'b0; end_cycle(1'b0);
    chk_en = 1'b0;
    resetn_i = 1'b0;
    #1;
    chk("reset mid-miss busy_o", 32'(busy_o), 32'd0);
    chk("reset mid-miss mem_req_o", 32'(mem_req_o), 32'd0);
    chk("reset mid-miss l1_pa_o", l1_pa_o, 32'd0);
    model_clear();
    exp_pa = '0;
    @(posedge clk_i); #1;
    resetn_i = 1'b1;
    chk_en = 1'b1;
    v0 = vld_count;
    for (int i = 0; i < 3; i++) begin
      set_exp(1'b0, 1'b0, 1'b0, '0); noise();
      l1_va_vld_i = 1'b0; mem_vld_i = 1'b1;
      end_cycle(1'b0);
    end
    chk("late fill no response", 32'(vld_count - v0), 32'd0);
    r0 = req_count;
    do_req(28'h0000400, 1'b0, 0, 0, 32'h44440401, 1'b0);
    chk("first after reset misses", 32'(req_count > r0), 32'd1);

    // Randomized traffic.
    inv_pct = 6;
    for (int n = 0; n < 200; n++) begin
      logic [27:0] va;
      if ($urandom_range(0, 9) == 0) w = 26'($urandom);
      else w = 26'(($urandom_range(0, 2) << 3) | $urandom_range(0, 7));
      va = {w, 2'($urandom)};
      do_req(va, $urandom_range(0, 4) == 0, int'($urandom_range(0, 3)),
             int'($urandom_range(0, 4)), $urandom, $urandom_range(0, 9) == 0);
      if ($urandom_range(0, 2) == 0) idle(int'($urandom_range(1, 3)));
    end
    idle(2);
    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
